// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, legality check, FSM states and flag bit indices shared by the ALU arbiter
package alu_pkg;
  localparam logic [3:0] IADD = 4'b0000;
  localparam logic [3:0] ISUB = 4'b0001;
  localparam logic [3:0] IAND = 4'b0010;
  localparam logic [3:0] IOR  = 4'b0011;
  localparam logic [3:0] IXOR = 4'b0100;
  localparam logic [3:0] ISLL = 4'b1000;
  localparam logic [3:0] ISLR = 4'b1001;
  localparam logic [3:0] ISRL = 4'b1010;
  localparam logic [3:0] ISRA = 4'b1011;
  localparam logic [3:0] INON = 4'b1111;
  localparam int FS = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {IADD, ISUB, IAND, IOR, IXOR, ISLL, ISLR, ISRL, ISRA, INON};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; last_q remembers the previous winner (resets to 1 so port 0 wins the first tie)
// ports: req_i requests, en_i grant enable, gnt_o one-hot grant, id_o index of the winner
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       id_o
);
  logic last_q, last_d;
  assign id_o  = &req_i ? ~last_q : req_i[1];
  assign gnt_o = (en_i && |req_i) ? (id_o ? 2'b10 : 2'b01) : 2'b00;
  assign last_d = |gnt_o ? id_o : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one stateless 16-bit ALU between two requesters, keeping per-requester SZCV flags
// ports: req0_*/req1_* valid/ready request channels, alu_* to/from the external ALU,
//        rsp_* registered response channel tagged with requester id, flags0_o/flags1_o flag registers
module alu_arbiter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req0_b_i,
  input  logic [3:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req1_b_i,
  input  logic [3:0]  req1_op_i,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [3:0]  alu_s_o,
  input  logic [15:0] alu_result_i,
  input  logic [3:0]  alu_flags_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_data_o,
  output logic [3:0]  rsp_flags_o,
  output logic        rsp_err_o,
  output logic [3:0]  flags0_o,
  output logic [3:0]  flags1_o
);
  state_e state_q, state_d;
  logic [1:0] gnt;
  logic gnt_id, id_q, legal, upd, rsp_id_q, rsp_err_q;
  logic [15:0] a_q, b_q, rsp_data_q;
  logic [3:0] op_q, rsp_flags_q, new_flags;
  logic [1:0][3:0] flags_q;
  // gating with rst_n keeps READY low while reset is held even if a request is present
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({req1_valid_i, req0_valid_i}),
    .en_i  (state_q == IDLE && rst_n),
    .gnt_o (gnt),
    .id_o  (gnt_id)
  );
  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign legal = is_legal(op_q);
  assign upd = legal && op_q != INON;
  assign new_flags = upd ? alu_flags_i : flags_q[id_q];
  assign alu_a_o = a_q;
  assign alu_b_o = b_q;
  assign alu_s_o = (state_q == EXEC && legal) ? op_q : INON;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_id_o = rsp_id_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_err_o = rsp_err_q;
  assign flags0_o = flags_q[0];
  assign flags1_o = flags_q[1];
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (|gnt ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              (rsp_ready_i ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= INON;
      id_q <= 1'b0;
      flags_q <= '0;
      rsp_id_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_flags_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        a_q <= gnt_id ? req1_a_i : req0_a_i;
        b_q <= gnt_id ? req1_b_i : req0_b_i;
        op_q <= gnt_id ? req1_op_i : req0_op_i;
        id_q <= gnt_id;
      end
      if (state_q == EXEC) begin
        flags_q[id_q] <= new_flags;
        rsp_id_q <= id_q;
        rsp_data_q <= upd ? alu_result_i : '0;
        rsp_flags_q <= new_flags;
        rsp_err_q <= !legal;
      end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 16-bit ALU between two requesters (port 0: execute stage, port 1: address-generation unit) under round-robin arbitration. Each request is accepted over a valid/ready handshake, executed in a dedicated ALU cycle and returned on a single registered response channel tagged with the requester ID. Per-requester SZCV flag registers are kept here, so the ALU itself stays stateless.

## Interface
- No parameters; data width fixed at 16, opcode width 4, flag width 4.
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous reset, active-low
- REQ0_VALID / REQ1_VALID  in  1  request present
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle
- REQ0_A, REQ0_B / REQ1_A, REQ1_B  in  16  operands
- REQ0_OP / REQ1_OP  in  4  ALU opcode
- ALU_A, ALU_B  out  16  operands to ALU
- ALU_S  out  4  opcode to ALU
- ALU_RESULT  in  16  ALU result
- ALU_FLAGS  in  4  ALU flags {S,Z,C,V}
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumed
- RSP_ID  out  1  requester of this response
- RSP_DATA  out  16  result
- RSP_FLAGS  out  4  requester's flag register after this op
- RSP_ERR  out  1  opcode was illegal
- FLAGS0, FLAGS1  out  4  per-requester flag registers

## Operation
- Legal opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 1000, SLR 1001, SRL 1010, SRA 1011, NON 1111. All others are illegal.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: if any REQx_VALID, grant one; assert its READY combinationally; latch A, B, OP, ID; go EXEC. No valid: stay IDLE, both READY low.
- Arbitration: both valid -> grant the requester not granted last; LAST register updates only on a grant; reset value 1, so port 0 wins the first tie.
- READY is low in EXEC and RESP; VALID without READY must be held by the requester with stable operands.
- EXEC: ALU_A/ALU_B = latched operands, ALU_S = latched OP (illegal -> 1111). At end of cycle capture ALU_RESULT into RSP_DATA; go RESP.
- Flag update at end of EXEC: legal op other than NON -> FLAGSid <= ALU_FLAGS. NON or illegal -> FLAGSid unchanged.
- RSP_FLAGS = FLAGSid value after the update. RSP_ERR = 1 for illegal opcodes; RSP_DATA = 0 for NON and illegal opcodes.
- RESP: RSP_VALID = 1 with RSP_* stable until RSP_READY; on RSP_READY go IDLE.
- Outside EXEC: ALU_S = 1111; ALU_A/ALU_B hold their last values.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, LAST = 1, FLAGS0 = FLAGS1 = 0, RSP_* = 0, ALU_A = ALU_B = 0, ALU_S = 1111, READY low.
- Reset mid-operation discards the in-flight request; no response is produced.
- Accept at edge N, EXEC during cycle N+1, RSP_VALID high from N+2.
- Minimum request-to-request spacing is 3 cycles, with RSP_READY tied high.
- A requester still valid after being served competes again in the next IDLE; round-robin prevents starvation (max wait is 1 other request).
- RSP_READY is ignored outside RESP.

## Structure
- Shared package alu_pkg: opcode localparams (IADD..INON), a legal-opcode check function, FSM state encoding (IDLE/EXEC/RESP), and flag bit indices S=3, Z=2, C=1, V=0.
- One natural sub-module: rr_arb2 (2-way round-robin grant with LAST register, grant-enable input).
- ALU instantiated by the parent next to this block, not inside it.

## Test plan
- Single request: REQ0 ADD 0x7FFF+0x0001 -> RSP_VALID at N+2, ID 0, DATA 0x8000, FLAGS 1001, FLAGS0 = 1001.
- Tie after reset: both valid continuously -> grant order 0,1,0,1; each response carries the matching ID.
- Flag isolation: REQ1 SUB 5-5 (FLAGS1 = 0100), then REQ1 NON -> DATA 0, RSP_FLAGS 0100, FLAGS0 unchanged.
- Illegal op: REQ0 OP 0101 -> ALU_S stays 1111, RSP_ERR 1, DATA 0, FLAGS0 unchanged.
- Backpressure: RSP_READY low for 5 cycles -> RSP_* stable, both READY low, no new grant.
- Reset during EXEC -> all outputs at reset values, no RSP_VALID afterwards, and the next request is served normally.
